// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// UART program loader: receives A5/N/data/CSUM frames into a 2048x16 instruction RAM and holds the CPU in reset while loading.
// Latency: dout is registered, 1 clk after adr; a received byte acts on the FSM 1 clk after its stop-bit sample.
// Backpressure: none; the serial link cannot be stalled. Optional echo is built only when LOADER_ECHO_EN is defined.
module prog_loader #(
    parameter int CLK_HZ  = 27000000,
    parameter int BAUD    = 115200,
    parameter int TIMEOUT = 2700000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic [10:0] adr,
    output logic [15:0] dout,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        load_err,
    output logic        uart_tx
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    typedef enum logic [2:0] {HUNT, LEN, DLO, DHI, CSUM} state_t;

    // Instruction RAM powers up zeroed and is never touched by rst_n.
    logic [15:0] mem [0:2047] = '{default: 16'h0000};

    logic          rx_meta, rx_s;
    logic          rx_busy, rx_vld, rx_ferr;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;

    state_t        state, state_n;
    logic [10:0]   wr_ptr, wr_ptr_n;
    logic [7:0]    sum, sum_n, lo, lo_n;
    logic [8:0]    nw, nw_n;
    logic          err_n, cpu_n, we, timeout;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // rx_bit: 0 = start (checked at half period), 1..8 = data, 9 = stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            rx_bit  <= 4'd0;
            rx_cnt  <= '0;
            rx_sh   <= 8'h00;
        end else begin
            rx_vld  <= 1'b0;
            rx_ferr <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s) begin
                    rx_busy <= 1'b1;
                    rx_bit  <= 4'd0;
                    rx_cnt  <= '0;
                end
            end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_M1 : DIV_M1)) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s) rx_busy <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_vld  <= rx_s;
                    rx_ferr <= !rx_s;
                end else begin
                    rx_sh <= {rx_s, rx_sh[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Counts clk cycles with the line idle inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == HUNT || rx_busy || rx_vld)
            to_cnt <= '0;
        else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state != HUNT) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            wr_ptr    <= 11'd0;
            sum       <= 8'h00;
            nw        <= 9'd0;
            lo        <= 8'h00;
            load_err  <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            sum       <= sum_n;
            nw        <= nw_n;
            lo        <= lo_n;
            load_err  <= err_n;
            cpu_rst_n <= cpu_n;
        end
    end

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        sum_n    = sum;
        nw_n     = nw;
        lo_n     = lo;
        err_n    = load_err;
        we       = 1'b0;
        if (state != HUNT && (rx_ferr || timeout)) begin
            err_n   = 1'b1;
            state_n = HUNT;
        end else if (rx_vld) begin
            case (state)
                HUNT: if (rx_sh == 8'hA5) begin
                    state_n  = LEN;
                    wr_ptr_n = 11'd0;
                    sum_n    = 8'h00;
                end
                LEN: begin
                    nw_n    = (rx_sh == 8'h00) ? 9'd256 : {1'b0, rx_sh};
                    state_n = DLO;
                end
                DLO: begin
                    lo_n    = rx_sh;
                    sum_n   = sum + rx_sh;
                    state_n = DHI;
                end
                DHI: begin
                    we       = 1'b1;
                    sum_n    = sum + rx_sh;
                    wr_ptr_n = wr_ptr + 11'd1;
                    state_n  = (wr_ptr_n == {2'b00, nw}) ? CSUM : DLO;
                end
                CSUM: begin
                    err_n   = (rx_sh != sum);
                    state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
        // The CPU runs only when idle with no outstanding error.
        cpu_n = (state_n == HUNT) && !err_n;
    end

    assign busy = (state != HUNT);

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= {rx_sh, lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= 16'h0000;
        else        dout <= mem[adr];
    end

`ifdef LOADER_ECHO_EN
    logic          tx_busy;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;
    logic [8:0]    tx_sh;

    // Bytes arriving while a transmission is in flight are simply not echoed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_bit  <= 4'd0;
            tx_cnt  <= '0;
            tx_sh   <= 9'h1FF;
            uart_tx <= 1'b1;
        end else if (!tx_busy) begin
            if (rx_vld) begin
                tx_busy <= 1'b1;
                tx_bit  <= 4'd0;
                tx_cnt  <= '0;
                tx_sh   <= {1'b1, rx_sh};
                uart_tx <= 1'b0;
            end
        end else if (tx_cnt == DIV_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                uart_tx <= 1'b1;
            end else begin
                uart_tx <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_bit  <= tx_bit + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end
`else
    assign uart_tx = 1'b1;
`endif

endmodule
